multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with a retired-instruction counter.
// Optional memory-wait timeout into a sticky ERR state is built when SEQ_MEM_TIMEOUT_EN is defined.
//
//   state  | meaning
//   FETCH  | request instruction word; IR/PC written when memory ready
//   DECODE | latch opcode into op_q
//   EXEC   | ALU setup, jump, branch resolve, or memory address phase
//   MEM    | data load/store; waits on mem_ready
//   WB     | register write-back (ALU result or load data)
//   ERR    | memory wait expired; left only by reset
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        equal,
  input  logic        less,
  input  logic        greater,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_st,
  output logic        mem_load,
  output logic        PC_WE,
  output logic        IR_WE,
  output logic        reg_write,
  output logic        imm_signal,
  output logic        jump,
  output logic        mem_alu,
  output logic        branch_mux,
  output logic        branch_sig,
  output logic [1:0]  alu_control,
  output logic [2:0]  state,
  output logic [15:0] retired,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  op_q;
  logic [15:0] retired_q;
  logic        br_taken;
  logic        timeout_hit;
  logic        retire;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 4'h0;
    end else if (state_q == S_DECODE) begin
      op_q <= opcode;
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;

  assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timeout_hit = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Counts only unbroken stall runs within one state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!waiting || (state_d != state_q)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign mem_err = rst_n && (state_q == S_ERR);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign mem_err            = 1'b0;
`endif

  always_comb begin
    br_taken = 1'b0;
    case (op_q)
      4'hB:    br_taken = equal;
      4'hC:    br_taken = less;
      4'hD:    br_taken = greater;
      4'hE:    br_taken = equal | less;
      4'hF:    br_taken = equal | greater;
      default: br_taken = 1'b0;
    endcase
  end

  // Outputs are held low while rst_n is low, even though state_q already reads FETCH.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_st      = 1'b0;
    mem_load    = 1'b0;
    PC_WE       = 1'b0;
    IR_WE       = 1'b0;
    reg_write   = 1'b0;
    imm_signal  = 1'b0;
    jump        = 1'b0;
    mem_alu     = 1'b0;
    branch_mux  = 1'b0;
    branch_sig  = 1'b0;
    alu_control = 2'b00;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IR_WE   = 1'b1;
            PC_WE   = 1'b1;
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_ERR;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          if (!op_q[3]) begin
            alu_control = op_q[2:1];
            imm_signal  = op_q[0];
            state_d     = S_WB;
          end else if (op_q == OP_JMP) begin
            jump    = 1'b1;
            PC_WE   = 1'b1;
            state_d = S_FETCH;
          end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
            mem_alu = 1'b1;
            state_d = S_MEM;
          end else begin
            branch_mux = 1'b1;
            branch_sig = br_taken;
            PC_WE      = br_taken;
            state_d    = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_alu  = 1'b1;
          mem_st   = (op_q == OP_ST);
          mem_load = (op_q == OP_LD);
          if (mem_ready) begin
            state_d = (op_q == OP_LD) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            state_d = S_ERR;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          mem_load  = (op_q == OP_LD);
          state_d   = S_FETCH;
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 16'h0000;
    end else if (retire) begin
      retired_q <= retired_q + 16'h0001;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: expected per-cycle outputs are built from the
// instruction class (fetch, optional memory phase, optional write-back) and compared each cycle.
module tb_multicycle_sequencer;

  logic        clock;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        equal, less, greater;
  logic        mem_ready;
  logic        mem_req, mem_st, mem_load, PC_WE, IR_WE, reg_write, imm_signal;
  logic        jump, mem_alu, branch_mux, branch_sig, mem_err;
  logic [1:0]  alu_control;
  logic [2:0]  state;
  logic [15:0] retired;

  int          tests;
  int          fails;
  logic [15:0] exp_ret;
  logic [16:0] obs;

  localparam logic [16:0] M_REQ  = 17'h02000;
  localparam logic [16:0] M_ST   = 17'h01000;
  localparam logic [16:0] M_LD   = 17'h00800;
  localparam logic [16:0] M_PC   = 17'h00400;
  localparam logic [16:0] M_IR   = 17'h00200;
  localparam logic [16:0] M_RW   = 17'h00100;
  localparam logic [16:0] M_IMM  = 17'h00080;
  localparam logic [16:0] M_JMP  = 17'h00040;
  localparam logic [16:0] M_MALU = 17'h00020;
  localparam logic [16:0] M_BMUX = 17'h00010;
  localparam logic [16:0] M_BSIG = 17'h00008;
  localparam logic [16:0] M_ERR  = 17'h00001;

  multicycle_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .equal       (equal),
    .less        (less),
    .greater     (greater),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_st      (mem_st),
    .mem_load    (mem_load),
    .PC_WE       (PC_WE),
    .IR_WE       (IR_WE),
    .reg_write   (reg_write),
    .imm_signal  (imm_signal),
    .jump        (jump),
    .mem_alu     (mem_alu),
    .branch_mux  (branch_mux),
    .branch_sig  (branch_sig),
    .alu_control (alu_control),
    .state       (state),
    .retired     (retired),
    .mem_err     (mem_err)
  );

  assign obs = {state, mem_req, mem_st, mem_load, PC_WE, IR_WE, reg_write, imm_signal,
                jump, mem_alu, branch_mux, branch_sig, alu_control, mem_err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] sv(input int s);
    return 17'(s) << 14;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  task automatic check_now(input logic [16:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
    tests++;
    assert (retired === exp_ret) else begin
      fails++;
      $error("FAIL %s_retired: observed %04h expected %04h", tag, retired, exp_ret);
    end
  endtask

  task automatic step(input logic rdy, input logic [16:0] exp, input string tag);
    mem_ready = rdy;
    @(negedge clock);
    check_now(exp, tag);
    @(posedge clock);
    #1;
  endtask

  // One instruction: fw stalled fetch cycles, mw stalled memory cycles.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic eq, input logic lt, input logic gt);
    logic [16:0] ex;
    logic        taken;
    opcode  = op;
    equal   = eq;
    less    = lt;
    greater = gt;
    for (int i = 0; i < fw; i++) step(1'b0, sv(0) | M_REQ, "fetch_wait");
    step(1'b1, sv(0) | M_REQ | M_PC | M_IR, "fetch");
    step(rnd_bit(), sv(1), "decode");
    opcode = 4'($urandom);
    if (op < 4'h8) begin
      ex = sv(2) | (17'(op[2:1]) << 1) | (op[0] ? M_IMM : 17'h0);
      step(rnd_bit(), ex, "exec_alu");
      step(rnd_bit(), sv(4) | M_RW, "wb_alu");
    end else if (op == 4'h8) begin
      step(rnd_bit(), sv(2) | M_JMP | M_PC, "exec_jump");
    end else if (op == 4'h9 || op == 4'hA) begin
      step(rnd_bit(), sv(2) | M_MALU, "exec_mem");
      ex = sv(3) | M_REQ | M_MALU | ((op == 4'h9) ? M_LD : M_ST);
      for (int i = 0; i < mw; i++) step(1'b0, ex, "mem_wait");
      step(1'b1, ex, "mem_done");
      if (op == 4'h9) step(rnd_bit(), sv(4) | M_RW | M_LD, "wb_load");
    end else begin
      case (op)
        4'hB:    taken = eq;
        4'hC:    taken = lt;
        4'hD:    taken = gt;
        4'hE:    taken = eq | lt;
        default: taken = eq | gt;
      endcase
      step(rnd_bit(), sv(2) | M_BMUX | (taken ? (M_BSIG | M_PC) : 17'h0), "exec_branch");
    end
    exp_ret = exp_ret + 16'd1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_ret   = 16'h0000;
    rst_n     = 1'b0;
    opcode    = 4'h0;
    equal     = 1'b0;
    less      = 1'b0;
    greater   = 1'b0;
    mem_ready = 1'b0;

    #2;
    check_now(17'h0, "reset_state");
    @(posedge clock);
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    // ADD then ADDI, no memory stalls
    run_instr(4'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(4'h1, 0, 0, 1'b0, 1'b0, 1'b0);

    // LD with a 3-cycle data stall, then bge taken and not taken
    run_instr(4'h9, 0, 3, 1'b0, 1'b0, 1'b0);
    run_instr(4'hF, 0, 0, 1'b0, 1'b0, 1'b1);
    run_instr(4'hF, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while a store sits in MEM
    opcode = 4'hA;
    step(1'b1, sv(0) | M_REQ | M_PC | M_IR, "st_fetch");
    step(rnd_bit(), sv(1), "st_decode");
    step(rnd_bit(), sv(2) | M_MALU, "st_exec");
    step(1'b0, sv(3) | M_REQ | M_MALU | M_ST, "st_mem_wait");
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_ret = 16'h0000;
    check_now(17'h0, "rst_mid_mem");
    @(posedge clock);
    #1;
    rst_n = 1'b1;

`ifdef SEQ_MEM_TIMEOUT_EN
    for (int i = 0; i < 8; i++) step(1'b0, sv(0) | M_REQ, "timeout_fetch");
    for (int i = 0; i < 4; i++) step(rnd_bit(), sv(5) | M_ERR, "err_hold");
    rst_n = 1'b0;
    #1;
    exp_ret = 16'h0000;
    check_now(17'h0, "rst_from_err");
    @(posedge clock);
    #1;
    rst_n = 1'b1;
`else
    for (int i = 0; i < 100; i++) step(1'b0, sv(0) | M_REQ, "unbounded_fetch");
`endif

    for (int n = 0; n < 40; n++) begin
      run_instr(4'($urandom), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                rnd_bit(), rnd_bit(), rnd_bit());
    end

    // Preload the count just below the wrap point, then retire one jump
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    run_instr(4'h8, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, sv(0) | M_REQ, "after_wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
